// File: rtl/enc_delta_counter.sv
// Quadrature encoder front end: synchronises A/B, decodes signed ticks and
// reports a saturated 16-bit displacement once per sample window.
module enc_delta_counter #(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] delta,
  output logic        delta_valid,
  output logic        sat,
  output logic        err
);

  localparam int PW           = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PRW          = $clog2(PRIME_CYCLES + 1);

  localparam logic [PW-1:0]  TERMINAL   = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PRW-1:0] PRIME_LAST = PRW'(PRIME_CYCLES - 1);

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [1:0]             s_cur;
  logic [1:0]             prev_q, prev_d;
  logic [PRW-1:0]         prime_q, prime_d;
  logic [PW-1:0]          period_q, period_d;
  logic [15:0]            count_q, count_d;
  logic                   win_sat_q, win_sat_d;
  logic                   win_err_q, win_err_d;
  logic [15:0]            delta_q, delta_d;
  logic                   sat_q, sat_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;

  logic                   step_up;
  logic                   step_dn;
  logic                   illegal;
  logic [16:0]            sum;
  logic                   clip;
  logic [15:0]            clamped;

  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b};
  end

  assign s_cur = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // Gray-code decode of the previous/current pair; a double-bit change is
  // not a direction, only an error.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    case ({prev_q, s_cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dn = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
      default: ;
    endcase
  end

  // Sign-extended 17-bit sum; disagreeing top bits mean the 16-bit range was left.
  always_comb begin
    sum     = {count_q[15], count_q} + {{16{step_dn}}, (step_up | step_dn)};
    clip    = sum[16] ^ sum[15];
    clamped = sum[15:0];
    if (clip) begin
      clamped = sum[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_comb begin
    state_d   = state_q;
    prime_d   = prime_q;
    prev_d    = s_cur;
    period_d  = period_q;
    count_d   = count_q;
    win_sat_d = win_sat_q;
    win_err_d = win_err_q;
    delta_d   = delta_q;
    sat_d     = sat_q;
    err_d     = err_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_PRIME: begin
        prime_d = prime_q + PRW'(1);
        if (prime_q == PRIME_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr) begin
          period_d  = '0;
          count_d   = '0;
          win_sat_d = 1'b0;
          win_err_d = 1'b0;
        end else if (en) begin
          if (period_q == TERMINAL) begin
            delta_d   = clamped;
            sat_d     = win_sat_q | clip;
            err_d     = win_err_q | illegal;
            valid_d   = 1'b1;
            period_d  = '0;
            count_d   = '0;
            win_sat_d = 1'b0;
            win_err_d = 1'b0;
          end else begin
            period_d  = period_q + PW'(1);
            count_d   = clamped;
            win_sat_d = win_sat_q | clip;
            win_err_d = win_err_q | illegal;
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PRIME;
      sync_a_q  <= '0;
      sync_b_q  <= '0;
      prev_q    <= '0;
      prime_q   <= '0;
      period_q  <= '0;
      count_q   <= '0;
      win_sat_q <= 1'b0;
      win_err_q <= 1'b0;
      delta_q   <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
      prev_q    <= prev_d;
      prime_q   <= prime_d;
      period_q  <= period_d;
      count_q   <= count_d;
      win_sat_q <= win_sat_d;
      win_err_q <= win_err_d;
      delta_q   <= delta_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  assign delta       = delta_q;
  assign delta_valid = valid_q;
  assign sat         = sat_q;
  assign err         = err_q;

endmodule
